// File: rtl/dmem_bridge_if.sv
// Split-handshake SRAM-like data bus between dmem_bridge and the cache/AXI adapter.
interface dmem_bridge_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [SW-1:0] wstrb;
  logic [DW-1:0] wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [DW-1:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// Data-port responder: turns one core M-stage access into one bus transaction,
// stalls the core while it is outstanding and holds read data while frozen.
module dmem_bridge (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_en,
  input  logic [31:0]         mem_addr,
  input  logic [3:0]          mem_wen,
  input  logic [31:0]         mem_wdata,
  input  logic                all_stall,
  output logic [31:0]         mem_rdata,
  output logic                d_stall,
  dmem_bridge_if.master       bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic          r_req;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [AW-1:0] r_addr;
  logic [SW-1:0] r_wstrb;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_is_wr;

  // Transfer size implied by a write's byte-enable pattern; unusual patterns fall back to word.
  function automatic logic [1:0] f_wr_size(input logic [SW-1:0] wen);
    logic [1:0] sz;
    case (wen)
      4'b1111:                            sz = 2'd2;
      4'b0011, 4'b1100:                   sz = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
      default:                            sz = 2'd2;
    endcase
    return sz;
  endfunction

  assign w_is_wr = |mem_wen;

  // Transaction FSM: latch in IDLE, present in REQ, collect in WAIT, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_en) begin
            r_addr  <= mem_addr;
            r_wr    <= w_is_wr;
            r_wstrb <= mem_wen;
            r_wdata <= mem_wdata;
            r_size  <= w_is_wr ? f_wr_size(mem_wen) : 2'd2;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.addr_ok) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.data_ok) begin
            if (!r_wr) r_rdata <= bus.rdata;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (!all_stall) r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Stall the core until the first DONE cycle; never stall while held in reset.
  assign d_stall   = mem_en & (r_state != S_DONE) & ~rst;

  assign mem_rdata = r_rdata;
  assign bus.req   = r_req;
  assign bus.wr    = r_wr;
  assign bus.size  = r_size;
  assign bus.addr  = r_addr;
  assign bus.wstrb = r_wstrb;
  assign bus.wdata = r_wdata;
endmodule
